reg_dump_reader: RTL and testbench

- Sequencer that drives the system's debug register-file read port (`testt_reg_add` / `testt_reg`) instead of a bench doing it by hand.
- On `start`, sweeps a contiguous register-address range and reads each register.
- Emits each value with its address on a valid/ready stream for a downstream consumer (UART framer, display scanner).
- Sits at top level beside `system`, wired to its debug port.

---
 rtl/reg_dump_reader.sv | 164 ++++++++++++++++
 tb/tb_reg_dump_reader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
// ---------------
// Walks a contiguous range of the system's debug register file and streams
// every value, tagged with its index, to a downstream consumer over a
// valid/ready handshake. It takes the place of a bench driving the debug
// read port by hand.
//
// Ports
//   SYS_clk, SYS_reset       clock; synchronous active-high reset
//   start, abort             begin a sweep (idle only) / end the current sweep
//   first_add, last_add      inclusive index range, latched on start
//   dbg_reg_add, dbg_reg     debug read port of the system (index out, value in)
//   out_valid, out_ready     stream handshake
//   out_data, out_add        captured value and its index
//   busy                     high whenever a sweep is in progress
//   done                     one-cycle pulse after the last word is accepted
//   err                      one-cycle pulse when start has first_add > last_add
//
// READ_LAT is the number of extra cycles the debug port needs after an index
// change before dbg_reg is valid (0..3, 0 = combinational read).

module reg_dump_reader #(
    parameter int READ_LAT = 0,
    parameter int ADDR_W   = 5
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_add,
    input  logic [ADDR_W-1:0] last_add,
    output logic [31:0]       dbg_reg_add,
    input  logic [31:0]       dbg_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_add,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    // Two bits cover every legal read latency (0..3).
    localparam int               CNT_W    = 2;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_add_q, out_add_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // The current index doubles as the debug-port index, so the port is
    // driven straight from a flop and always lies within the latched range.
    assign dbg_reg_add = {{(32 - ADDR_W){1'b0}}, cur_q};
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_add     = out_add_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_add_d   = out_add_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A simultaneous abort suppresses the start.
                if (start && !abort) begin
                    if (first_add <= last_add) begin
                        cur_d   = first_add;
                        last_d  = last_add;
                        cnt_d   = LAT_LOAD;
                        state_d = S_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    out_data_d  = dbg_reg;
                    out_add_d   = cur_q;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end

            S_HOLD: begin
                // Abort wins over a handshake in the same cycle: the word is
                // consumed but the sweep ends without done.
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    // Compare before incrementing so an inclusive limit at
                    // the top index never wraps back to zero.
                    if (cur_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cur_d   = cur_q + ADDR_W'(1);
                        cnt_d   = LAT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_add_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_add_q   <= out_add_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader. Two instances run side by side: index 0 with a
// combinational debug read, index 1 with a two-cycle read latency. The
// register file is an array in the bench; each sweep's expected word list is
// built from it up front and consumed as words are accepted.

module tb_reg_dump_reader;

    localparam int ADDR_W       = 5;
    localparam int SWEEP_BUDGET = 2000;

    logic sysClk   = 1'b0;
    logic sysReset = 1'b1;

    always #5 sysClk = ~sysClk;

    logic              startIn [2];
    logic              abortIn [2];
    logic              readyIn [2];
    logic [ADDR_W-1:0] firstIn [2];
    logic [ADDR_W-1:0] lastIn  [2];

    logic [31:0]       dbgAdd0, dbgAdd2, dbgReg0, dbgReg2, outData0, outData2;
    logic [ADDR_W-1:0] outAdd0, outAdd2;
    logic              outValid0, outValid2, busy0, busy2, done0, done2, err0, err2;

    logic [31:0]       dbgAdd   [2];
    logic [31:0]       outData  [2];
    logic [ADDR_W-1:0] outAdd   [2];
    logic              outValid [2];
    logic              busy     [2];
    logic              done     [2];
    logic              err      [2];

    logic [31:0]       regFile [32];
    logic [ADDR_W-1:0] addrPipe1 = '0;
    logic [ADDR_W-1:0] addrPipe2 = '0;

    int testsRun    = 0;
    int testsFailed = 0;

    // Gather both instances' outputs into arrays so tasks can pick one.
    always_comb begin
        dbgAdd[0]   = dbgAdd0;   dbgAdd[1]   = dbgAdd2;
        outData[0]  = outData0;  outData[1]  = outData2;
        outAdd[0]   = outAdd0;   outAdd[1]   = outAdd2;
        outValid[0] = outValid0; outValid[1] = outValid2;
        busy[0]     = busy0;     busy[1]     = busy2;
        done[0]     = done0;     done[1]     = done2;
        err[0]      = err0;      err[1]      = err2;
    end

    // Combinational register file for the zero-latency instance.
    assign dbgReg0 = regFile[dbgAdd0[ADDR_W-1:0]];

    // The slow register file answers for the index seen two edges ago, so an
    // early capture returns the previous register's value.
    always @(posedge sysClk) begin
        addrPipe1 <= dbgAdd2[ADDR_W-1:0];
        addrPipe2 <= addrPipe1;
    end
    assign dbgReg2 = regFile[addrPipe2];

    reg_dump_reader #(.READ_LAT(0), .ADDR_W(ADDR_W)) dut0 (
        .SYS_clk(sysClk), .SYS_reset(sysReset),
        .start(startIn[0]), .abort(abortIn[0]),
        .first_add(firstIn[0]), .last_add(lastIn[0]),
        .dbg_reg_add(dbgAdd0), .dbg_reg(dbgReg0),
        .out_valid(outValid0), .out_ready(readyIn[0]),
        .out_data(outData0), .out_add(outAdd0),
        .busy(busy0), .done(done0), .err(err0)
    );

    reg_dump_reader #(.READ_LAT(2), .ADDR_W(ADDR_W)) dut2 (
        .SYS_clk(sysClk), .SYS_reset(sysReset),
        .start(startIn[1]), .abort(abortIn[1]),
        .first_add(firstIn[1]), .last_add(lastIn[1]),
        .dbg_reg_add(dbgAdd2), .dbg_reg(dbgReg2),
        .out_valid(outValid2), .out_ready(readyIn[1]),
        .out_data(outData2), .out_add(outAdd2),
        .busy(busy2), .done(done2), .err(err2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge sysClk);
        #1;
    endtask

    // Pulse start for one edge; returns just after the start edge.
    task automatic applyStimulus(input int which, input int first, input int last);
        firstIn[which] = ADDR_W'(first);
        lastIn[which]  = ADDR_W'(last);
        startIn[which] = 1'b1;
        tick;
        startIn[which] = 1'b0;
    endtask

    task automatic idleCheck(input int which);
        tick;
        checkOutput("idle_done", 32'(done[which]), 32'd0);
        checkOutput("idle_busy", 32'(busy[which]), 32'd0);
        checkOutput("idle_valid", 32'(outValid[which]), 32'd0);
    endtask

    // Runs one sweep and checks every accepted word against the list built
    // from regFile. Returns in the cycle the sweep has just ended.
    task automatic collectSweep(input int which, input int first, input int last,
                                input int readyPct, input int stallIdx,
                                input int abortIdx, input bit abortWithHs,
                                input bit pokeStart);
        int          expAdd [$];
        logic [31:0] expData [$];
        int          lat, cycle, lastHs, stall, idx;
        bit          holdPrev, hs, finished;
        logic [31:0] prevData;
        logic [ADDR_W-1:0] prevAdd;

        lat = (which == 0) ? 0 : 2;
        cycle = 0; lastHs = 0; stall = 0; idx = 0;
        holdPrev = 1'b0; finished = 1'b0;
        prevData = '0; prevAdd = '0;
        for (int i = first; i <= last; i++) begin
            expAdd.push_back(i);
            expData.push_back((i == 0) ? 32'h0 : regFile[i]);
        end

        applyStimulus(which, first, last);
        checkOutput("busy_after_start", 32'(busy[which]), 32'd1);

        while (!finished && cycle < SWEEP_BUDGET) begin
            checkOutput("dbg_reg_add", dbgAdd[which], 32'(expAdd[0]));
            checkOutput("no_early_done", 32'(done[which]), 32'd0);
            if (holdPrev) begin
                checkOutput("hold_valid", 32'(outValid[which]), 32'd1);
                checkOutput("hold_data", outData[which], prevData);
                checkOutput("hold_add", 32'(outAdd[which]), 32'(prevAdd));
            end

            readyIn[which] = ($urandom_range(1, 100) <= readyPct);
            if (idx == stallIdx && outValid[which] && stall < 5) begin
                readyIn[which] = 1'b0;
                stall++;
            end
            if (idx == abortIdx && outValid[which]) begin
                abortIn[which] = 1'b1;
                readyIn[which] = abortWithHs;
            end
            if (pokeStart && cycle == 3) begin
                startIn[which] = 1'b1;
                firstIn[which] = '0;
                lastIn[which]  = '1;
            end

            hs = outValid[which] && readyIn[which];
            if (hs) begin
                checkOutput("word_add", 32'(outAdd[which]), 32'(expAdd[0]));
                checkOutput("word_data", outData[which], expData[0]);
                if (readyPct == 100 && stallIdx < 0)
                    checkOutput("word_spacing", 32'(cycle + 1 - lastHs), 32'(2 + lat));
                lastHs = cycle + 1;
            end
            holdPrev = outValid[which] && !hs;
            prevData = outData[which];
            prevAdd  = outAdd[which];

            tick;
            cycle++;
            startIn[which] = 1'b0;
            if (hs) begin
                void'(expAdd.pop_front());
                void'(expData.pop_front());
                idx++;
            end

            if (abortIn[which]) begin
                abortIn[which] = 1'b0;
                finished = 1'b1;
                checkOutput("abort_valid", 32'(outValid[which]), 32'd0);
                checkOutput("abort_busy", 32'(busy[which]), 32'd0);
                checkOutput("abort_no_done", 32'(done[which]), 32'd0);
            end else if (expAdd.size() == 0) begin
                finished = 1'b1;
                checkOutput("done_pulse", 32'(done[which]), 32'd1);
                checkOutput("end_valid", 32'(outValid[which]), 32'd0);
                checkOutput("end_busy", 32'(busy[which]), 32'd0);
            end
        end
        checkOutput("sweep_finished", 32'(finished), 32'd1);
        readyIn[which] = 1'b0;
    endtask

    // Safety net in case the clock or a task wedges.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            startIn[d] = 1'b0; abortIn[d] = 1'b0; readyIn[d] = 1'b0;
            firstIn[d] = '0;   lastIn[d]  = '0;
        end
        for (int i = 0; i < 32; i++)
            regFile[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);

        // Reset values
        tick;
        tick;
        checkOutput("rst_dbg_add", dbgAdd[0], 32'd0);
        checkOutput("rst_valid", 32'(outValid[0]), 32'd0);
        checkOutput("rst_data", outData[0], 32'd0);
        checkOutput("rst_add", 32'(outAdd[0]), 32'd0);
        checkOutput("rst_busy", 32'(busy[0]), 32'd0);
        checkOutput("rst_done", 32'(done[0]), 32'd0);
        checkOutput("rst_err", 32'(err[0]), 32'd0);
        checkOutput("rst_busy_slow", 32'(busy[1]), 32'd0);
        sysReset = 1'b0;
        tick;

        // Full sweep, zero latency, two cycles per word
        collectSweep(0, 0, 31, 100, -1, -1, 1'b0, 1'b0);
        idleCheck(0);

        // Backpressure on the middle word of 8..10
        collectSweep(0, 8, 10, 100, 1, -1, 1'b0, 1'b0);
        idleCheck(0);

        // Read latency of two: valid three edges after start
        regFile[16] = 32'hDEAD_BEEF;
        applyStimulus(1, 16, 16);
        checkOutput("lat_valid_e0", 32'(outValid[1]), 32'd0);
        tick;
        checkOutput("lat_valid_e1", 32'(outValid[1]), 32'd0);
        tick;
        checkOutput("lat_valid_e2", 32'(outValid[1]), 32'd0);
        tick;
        checkOutput("lat_valid_e3", 32'(outValid[1]), 32'd1);
        checkOutput("lat_data", outData[1], 32'hDEAD_BEEF);
        checkOutput("lat_add", 32'(outAdd[1]), 32'd16);
        readyIn[1] = 1'b1;
        tick;
        readyIn[1] = 1'b0;
        checkOutput("lat_done", 32'(done[1]), 32'd1);
        idleCheck(1);
        collectSweep(1, 0, 31, 100, -1, -1, 1'b0, 1'b0);
        idleCheck(1);

        // Inverted range raises err only
        firstIn[0] = 5'd12;
        lastIn[0]  = 5'd4;
        startIn[0] = 1'b1;
        tick;
        startIn[0] = 1'b0;
        checkOutput("err_pulse", 32'(err[0]), 32'd1);
        checkOutput("err_busy", 32'(busy[0]), 32'd0);
        tick;
        checkOutput("err_cleared", 32'(err[0]), 32'd0);
        checkOutput("err_busy_after", 32'(busy[0]), 32'd0);

        // A second start mid-sweep is ignored
        collectSweep(0, 2, 9, 70, -1, -1, 1'b0, 1'b1);
        idleCheck(0);

        // Abort in HOLD on word 3, then a clean restart
        collectSweep(0, 0, 31, 100, -1, 3, 1'b0, 1'b0);
        idleCheck(0);
        collectSweep(0, 20, 23, 100, -1, -1, 1'b0, 1'b0);
        idleCheck(0);

        // Abort together with a handshake
        collectSweep(0, 0, 31, 100, -1, 3, 1'b1, 1'b0);
        idleCheck(0);

        // Reset while waiting for word 2
        applyStimulus(0, 0, 31);
        readyIn[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        checkOutput("pre_rst_valid", 32'(outValid[0]), 32'd0);
        checkOutput("pre_rst_busy", 32'(busy[0]), 32'd1);
        sysReset = 1'b1;
        tick;
        readyIn[0] = 1'b0;
        checkOutput("mid_rst_dbg_add", dbgAdd[0], 32'd0);
        checkOutput("mid_rst_valid", 32'(outValid[0]), 32'd0);
        checkOutput("mid_rst_data", outData[0], 32'd0);
        checkOutput("mid_rst_add", 32'(outAdd[0]), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy[0]), 32'd0);
        checkOutput("mid_rst_done", 32'(done[0]), 32'd0);
        checkOutput("mid_rst_err", 32'(err[0]), 32'd0);
        sysReset = 1'b0;
        tick;
        collectSweep(0, 5, 7, 60, -1, -1, 1'b0, 1'b0);
        idleCheck(0);

        // Top index alone, then a start in the done cycle
        collectSweep(0, 31, 31, 100, -1, -1, 1'b0, 1'b0);
        collectSweep(0, 30, 31, 100, -1, -1, 1'b0, 1'b0);
        idleCheck(0);

        // Random contents, ranges and consumer behaviour on both instances
        for (int i = 1; i < 32; i++) regFile[i] = $urandom;
        for (int n = 0; n < 8; n++) begin
            int which, a, b, pct;
            which = int'($urandom_range(0, 1));
            a     = int'($urandom_range(0, 31));
            b     = int'($urandom_range(a, 31));
            pct   = int'($urandom_range(30, 100));
            collectSweep(which, a, b, pct, -1, -1, 1'b0, 1'b0);
            idleCheck(which);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
